tt_um_serial_adder_seq: RTL and testbench
=========================================

// Module: tt_um_serial_adder_seq
// PURPOSE
//  Bit-serial add/subtract sequencer: one full-adder cell (two half adders plus carry
//  flop) is reused LSB-first over WIDTH cycles to add or subtract two operands.
//  Operands come from ui_in, controls from uio_in. Result and status go to uo_out.
//  Top-level TinyTapeout tile. Sits alongside the combinational half-adder tile as its
//  sequenced, area-reusing counterpart.
// PARAMETERS
//  WIDTH  4  operand width in bits. Fixed by pin count: A=ui_in[3:0], B=ui_in[7:4].
// PORTS
//  clk      in   1  clock; all state updates on rising edge
//  rst_n    in   1  reset, asynchronous, active-low
//  ena      in   1  1=run, 0=freeze all state (hold)
//  ui_in    in   8  [3:0]=operand A, [7:4]=operand B
//  uio_in   in   8  [0]=start (level; internally edge-detected), [1]=mode (0 add, 1 sub A-B), [7:2] unused
//  uo_out   out  8  [4:0]=result, [5]=busy, [6]=done, [7]=0
//  uio_out  out  8  tied 0
//  uio_oe   out  8  tied 0 (all uio pins inputs)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE. Result, busy, done, start_q, carry, count all 0.
//  - start_q registers uio_in[0] every enabled edge.
//  - Start event: uio_in[0]=1 and start_q=0 at the edge.
//  - FSM: IDLE, RUN, DONE.
//    IDLE/DONE + start event -> RUN.
//      Capture A, B, mode into shift regs. carry<=mode; B inverted when mode=1.
//      count<=0; done<=0; busy<=1.
//    RUN, each edge:
//      s=a0^b0^carry via half adder pair; carry<=majority(a0,b0,carry).
//      s shifts into sum shift reg at MSB; operand regs shift right; count++.
//    RUN, edge where count==WIDTH-1 -> DONE. busy<=0, done<=1, result<=final value:
//      result[WIDTH-1:0] = sum bits.
//      result[WIDTH] = carry-out (add) or borrow = ~carry-out (sub).
//  - Latency: calling the capture edge E0, done and result appear after edge E(WIDTH),
//    i.e. WIDTH+1 edges total. Result and busy change together on that edge.
//  - uo_out[4:0] holds the previous result during RUN. It updates only on RUN->DONE.
//  - done stays 1 in DONE until the next start event. Exactly one done rise per operation.
//  - Start events in RUN are ignored. start_q still tracks the pin.
//  - A start held high does not retrigger. A new start needs a low level seen first.
//  - ui_in and mode changes after E0 do not affect the running operation.
//  - ena=0: no state, counter, start_q or output change. Resumes exactly where frozen.
//  - Reset mid-RUN: immediate return to IDLE, all outputs 0, the operation is discarded.
//  - busy and done are never both 1.
// TESTING
//  1 Reset: rst_n=0 with ui_in=0xFF and start=1 -> uo_out=0x00, uio_out=0, uio_oe=0.
//    Release -> stays 0x00 until a start event.
//  2 Add 5+3: ui_in=0x35, mode=0, start 0->1 -> busy=1 for 4 edges.
//    After E4: uo_out=0x48 (sum 0x08, done).
//  3 Add 15+15 then sub 3-5:
//    ui_in=0xFF add -> uo_out=0x5E.
//    Then ui_in=0x53, mode=1 -> uo_out=0x5E (0xE, borrow=1).
//    Sub 9-4 (ui_in=0x49) -> 0x45.
//  4 Start held high through DONE -> no second run.
//    Start pulse during RUN, or ui_in changed mid-RUN -> result unchanged from the E0 operands.
//  5 rst_n low at E2 of an add -> uo_out=0x00 at once.
//    After release, a new 1+1 -> 0x42.
//  6 ena=0 for 3 cycles mid-RUN -> busy held, done delayed by exactly 3 edges, same result.

Source files
------------

// File: rtl/tt_um_serial_adder_seq.sv
// tt_um_serial_adder_seq: bit-serial add/subtract sequencer reusing one full-adder cell LSB-first
module tt_um_serial_adder_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int WIDTH = 4;
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic [WIDTH:0] result;
    logic [CW-1:0] count;
    logic carry, mode_q, start_q, busy, done;
    logic s1, c1, s, c2, cout, start_ev, last;
    logic unused_ok;
    assign s1 = a_sr[0] ^ b_sr[0];
    assign c1 = a_sr[0] & b_sr[0];
    assign s = s1 ^ carry;
    assign c2 = s1 & carry;
    assign cout = c1 | c2;
    assign start_ev = uio_in[0] & ~start_q;
    assign last = count == CW'(WIDTH - 1);
    assign uo_out = {1'b0, done, busy, result};
    assign uio_out = 8'h00;
    assign uio_oe = 8'h00;
    assign unused_ok = &{1'b0, uio_in[7:2]};
    // Sequencer: capture operands on a start edge, then one full-adder step per edge until the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr <= '0;
            b_sr <= '0;
            sum_sr <= '0;
            result <= '0;
            count <= '0;
            carry <= 1'b0;
            mode_q <= 1'b0;
            start_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[0];
            if (state != RUN && start_ev) begin
                state <= RUN;
                a_sr <= ui_in[WIDTH-1:0];
                b_sr <= ui_in[7:4] ^ {WIDTH{uio_in[1]}};
                carry <= uio_in[1];
                mode_q <= uio_in[1];
                count <= '0;
                done <= 1'b0;
                busy <= 1'b1;
            end else if (state == RUN) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                sum_sr <= {s, sum_sr[WIDTH-1:1]};
                carry <= cout;
                count <= count + 1'b1;
                if (last) begin
                    state <= DONE;
                    busy <= 1'b0;
                    done <= 1'b1;
                    result <= {mode_q ? ~cout : cout, s, sum_sr[WIDTH-1:1]};
                end
            end
        end
    end
endmodule

// File: tb/tb_tt_um_serial_adder_seq.sv
// tb_tt_um_serial_adder_seq: directed bench with an arithmetic reference model checked every cycle
module tb_tt_um_serial_adder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    logic [7:0] ui_in = 8'hFF;
    logic [7:0] uio_in = 8'h01;
    logic [7:0] uo_out, uio_out, uio_oe;
    int total = 0;
    int passed = 0;
    logic m_busy, m_done, m_prev;
    logic [4:0] m_res, m_pend;
    int m_left;

    tt_um_serial_adder_seq dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] arith(input logic [7:0] ui, input logic m);
        int a, b, x;
        a = int'(ui[3:0]);
        b = int'(ui[7:4]);
        x = m ? a - b : a + b;
        return m ? {a < b, x[3:0]} : x[4:0];
    endfunction

    // Reference: an operation started on a fresh start level finishes 4 enabled edges later with its arithmetic result
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_prev <= 1'b0;
            m_res <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (ena) begin
            m_prev <= uio_in[0];
            if (!m_busy && uio_in[0] && !m_prev) begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_left <= 4;
                m_pend <= arith(ui_in, uio_in[1]);
            end else if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res <= m_pend;
                end
            end
        end
    end

    // Every-cycle comparison against the reference, away from the active edge
    always @(negedge clk) begin
        total++;
        if (uo_out === {1'b0, m_done, m_busy, m_res} && uio_out === 8'h00 && uio_oe === 8'h00)
            passed++;
        else
            $display("FAIL model t=%0t uo_out=%h expected=%h uio_out=%h uio_oe=%h", $time, uo_out,
                     {1'b0, m_done, m_busy, m_res}, uio_out, uio_oe);
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op(input string name, input logic [7:0] ui, input logic mode,
                      input logic [4:0] prev, input logic [7:0] exp);
        ui_in = ui;
        uio_in = {6'b0, mode, 1'b0};
        tick(1);
        uio_in[0] = 1'b1;
        tick(1);
        chk({name, "_busy"}, uo_out, {3'b001, prev});
        tick(3);
        chk({name, "_e3"}, uo_out, {3'b001, prev});
        tick(1);
        chk(name, uo_out, exp);
    endtask

    initial begin
        tick(2);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h00);
        uio_in = 8'h00;
        rst_n = 1'b1;
        tick(3);
        chk("rst_release", uo_out, 8'h00);
        op("add5p3", 8'h35, 1'b0, 5'h00, 8'h48);
        op("add15p15", 8'hFF, 1'b0, 5'h08, 8'h5E);
        op("sub3m5", 8'h53, 1'b1, 5'h1E, 8'h5E);
        op("sub9m4", 8'h49, 1'b1, 5'h1E, 8'h45);
        tick(6);
        chk("held_start", uo_out, 8'h45);
        uio_in = 8'h00;
        ui_in = 8'h12;
        tick(1);
        uio_in[0] = 1'b1;
        tick(1);
        uio_in[0] = 1'b0;
        tick(1);
        ui_in = 8'hFF;
        uio_in = 8'h03;
        tick(1);
        uio_in = 8'h00;
        tick(1);
        chk("midrun_e3", uo_out, 8'h25);
        tick(1);
        chk("midrun_ignore", uo_out, 8'h43);
        ui_in = 8'h77;
        tick(1);
        uio_in[0] = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("async_rst", uo_out, 8'h00);
        uio_in = 8'h00;
        tick(1);
        rst_n = 1'b1;
        op("add1p1", 8'h11, 1'b0, 5'h00, 8'h42);
        uio_in = 8'h00;
        ui_in = 8'h27;
        tick(1);
        uio_in[0] = 1'b1;
        tick(2);
        ena = 1'b0;
        tick(3);
        chk("freeze", uo_out, 8'h22);
        ena = 1'b1;
        tick(2);
        chk("resume_e3", uo_out, 8'h22);
        tick(1);
        chk("resume_done", uo_out, 8'h49);
        tick(3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
